complex_accumulator: RTL and testbench



---
 rtl/cplx_pkg.sv | 29 ++
 rtl/sat_trunc.sv | 33 +++
 rtl/complex_accumulator.sv | 133 +++++++++++++
 tb/tb_complex_accumulator.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cplx_pkg.sv
// Shared widths, state encoding and signed-range helpers for the complex datapath stages.
package cplx_pkg;

    localparam int unsigned DEF_IN_W = 16;
    localparam int unsigned PROD_W   = 2 * 8;

    typedef enum logic [0:0] {
        StIdle,
        StAccum
    } acc_state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic longint sat_max(input int unsigned w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int unsigned w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/sat_trunc.sv
// Signed narrowing with clamp to the output range; clip flags a clamped value.
module sat_trunc
    import cplx_pkg::*;
#(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    if (OUT_W >= IN_W) begin : g_ext
        assign dout = OUT_W'(din);
        assign clip = 1'b0;
    end else begin : g_sat
        localparam logic signed [IN_W-1:0] MAX_V = IN_W'(sat_max(OUT_W));
        localparam logic signed [IN_W-1:0] MIN_V = IN_W'(sat_min(OUT_W));

        always_comb begin
            dout = din[OUT_W-1:0];
            clip = 1'b0;
            if (din > MAX_V) begin
                dout = {1'b0, {(OUT_W-1){1'b1}}};
                clip = 1'b1;
            end else if (din < MIN_V) begin
                dout = {1'b1, {(OUT_W-1){1'b0}}};
                clip = 1'b1;
            end
        end
    end

endmodule

// File: rtl/complex_accumulator.sv
// Sums N_ACC valid complex products into one saturated result with a one-cycle valid pulse.
module complex_accumulator
    import cplx_pkg::*;
#(
    parameter int unsigned IN_W  = DEF_IN_W,
    parameter int unsigned N_ACC = 4,
    parameter int unsigned OUT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [IN_W-1:0]  Re_in,
    input  logic signed [IN_W-1:0]  Im_in,
    input  logic                    data_valid_in,
    input  logic                    clear,
    output logic signed [OUT_W-1:0] Re_acc,
    output logic signed [OUT_W-1:0] Im_acc,
    output logic                    data_valid_out,
    output logic                    sat_flag
);

    localparam int unsigned ACC_W = IN_W + clog2(N_ACC);
    localparam int unsigned CNT_W = (clog2(N_ACC) > 0) ? clog2(N_ACC) : 1;

    acc_state_e state_q, state_d;

    logic [CNT_W-1:0]        cnt_q;
    logic signed [ACC_W-1:0] acc_re_q, acc_im_q;
    logic signed [ACC_W-1:0] in_re, in_im, sum_re, sum_im;
    logic signed [OUT_W-1:0] sat_re, sat_im;
    logic signed [OUT_W-1:0] re_acc_q, im_acc_q;
    logic                    clip_re, clip_im;
    logic                    valid_q, sat_q;
    logic                    take, last;
    logic                    first_load, acc_add, acc_zero, res_load;

    // Clear wins over a same-cycle sample, so a dropped sample never counts.
    assign take   = data_valid_in & ~clear;
    assign last   = (cnt_q == CNT_W'(N_ACC - 1));
    assign in_re  = ACC_W'(Re_in);
    assign in_im  = ACC_W'(Im_in);
    assign sum_re = acc_re_q + in_re;
    assign sum_im = acc_im_q + in_im;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (take && !last) state_d = StAccum;
            StAccum: if (clear || (take && last)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        first_load = 1'b0;
        acc_add    = 1'b0;
        acc_zero   = clear;
        res_load   = take & last;
        unique case (state_q)
            StIdle:  first_load = take & ~last;
            StAccum: acc_add    = take & ~last;
            default: acc_zero   = 1'b1;
        endcase
        if (res_load) acc_zero = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
        end else if (acc_zero) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
            cnt_q    <= '0;
        end else if (first_load) begin
            acc_re_q <= in_re;
            acc_im_q <= in_im;
            cnt_q    <= CNT_W'(1);
        end else if (acc_add) begin
            acc_re_q <= sum_re;
            acc_im_q <= sum_im;
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_re (
        .din  (sum_re),
        .dout (sat_re),
        .clip (clip_re)
    );

    sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (OUT_W)
    ) u_sat_im (
        .din  (sum_im),
        .dout (sat_im),
        .clip (clip_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            re_acc_q <= '0;
            im_acc_q <= '0;
            valid_q  <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            valid_q <= res_load;
            if (res_load) begin
                re_acc_q <= sat_re;
                im_acc_q <= sat_im;
                sat_q    <= clip_re | clip_im;
            end
        end
    end

    assign Re_acc         = re_acc_q;
    assign Im_acc         = im_acc_q;
    assign data_valid_out = valid_q;
    assign sat_flag       = sat_q;

endmodule

// File: tb/tb_complex_accumulator.sv
// Directed bench for complex_accumulator with an integer frame model and per-cycle compare.
module tb_complex_accumulator;

    localparam int N = 4;

    logic               clk;
    logic               rst_n;
    logic signed [15:0] Re_in, Im_in;
    logic               data_valid_in;
    logic               clear;
    logic signed [15:0] Re_acc, Im_acc;
    logic               data_valid_out;
    logic               sat_flag;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    typedef struct {
        int re;
        int im;
        int sat;
        int cyc;
    } res_t;

    res_t pulses[$];

    complex_accumulator #(
        .IN_W  (16),
        .N_ACC (N),
        .OUT_W (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Re_in          (Re_in),
        .Im_in          (Im_in),
        .data_valid_in  (data_valid_in),
        .clear          (clear),
        .Re_acc         (Re_acc),
        .Im_acc         (Im_acc),
        .data_valid_out (data_valid_out),
        .sat_flag       (sat_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int clamp(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Frame model: running integer sums and a sample count.
    int m_re, m_im, m_cnt;
    int e_re, e_im, e_v, e_sat;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_re <= 0; m_im <= 0; m_cnt <= 0;
            e_re <= 0; e_im <= 0; e_v <= 0; e_sat <= 0;
        end else begin
            e_v <= 0;
            if (clear) begin
                m_re <= 0; m_im <= 0; m_cnt <= 0;
            end else if (data_valid_in) begin
                if (m_cnt + 1 == N) begin
                    e_re  <= clamp(m_re + int'(Re_in));
                    e_im  <= clamp(m_im + int'(Im_in));
                    e_sat <= (clamp(m_re + int'(Re_in)) != m_re + int'(Re_in)) ||
                             (clamp(m_im + int'(Im_in)) != m_im + int'(Im_in));
                    e_v   <= 1;
                    m_re <= 0; m_im <= 0; m_cnt <= 0;
                end else begin
                    m_re  <= m_re + int'(Re_in);
                    m_im  <= m_im + int'(Im_in);
                    m_cnt <= m_cnt + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        cycle++;
        chk("valid_out", longint'(data_valid_out), longint'(e_v));
        chk("re_acc", longint'(Re_acc), longint'(e_re));
        chk("im_acc", longint'(Im_acc), longint'(e_im));
        chk("sat_flag", longint'(sat_flag), longint'(e_sat));
        if (data_valid_out === 1'b1)
            pulses.push_back('{re: int'(Re_acc), im: int'(Im_acc), sat: int'(sat_flag), cyc: cycle});
    end

    task automatic cyc(input int re, input int im, input logic v, input logic c);
        @(negedge clk);
        Re_in         = 16'(re);
        Im_in         = 16'(im);
        data_valid_in = v;
        clear         = c;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(int'($urandom), int'($urandom), 1'b0, 1'b0);
    endtask

    task automatic burst(input int n, input int re, input int im);
        repeat (n) cyc(re, im, 1'b1, 1'b0);
    endtask

    task automatic expect_pulse(input string name, input int idx, input int re, input int im,
                                input int sat);
        if (idx < pulses.size()) begin
            chk({name, "_re"}, pulses[idx].re, re);
            chk({name, "_im"}, pulses[idx].im, im);
            chk({name, "_sat"}, pulses[idx].sat, sat);
        end else begin
            chk({name, "_present"}, pulses.size(), idx + 1);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        Re_in = '0; Im_in = '0; data_valid_in = 1'b0; clear = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_re", Re_acc, 0);
        chk("reset_valid", data_valid_out, 0);
        chk("reset_sat", sat_flag, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back frame of 8+6i.
        burst(4, 8, 6);
        idle(2);
        chk("t1_count", pulses.size(), 1);
        expect_pulse("t1", 0, 32, 24, 0);
        pulses.delete();

        // Same frame with idle gaps.
        for (int i = 0; i < 4; i++) begin
            burst(1, 8, 6);
            idle(2 + (i % 2));
        end
        chk("t2_count", pulses.size(), 1);
        expect_pulse("t2", 0, 32, 24, 0);
        pulses.delete();

        // Saturation, then a clean frame clears sat_flag.
        burst(4, 16000, -16000);
        idle(1);
        burst(4, 1, 1);
        idle(2);
        chk("t3_count", pulses.size(), 2);
        expect_pulse("t3a", 0, 32767, -32768, 1);
        expect_pulse("t3b", 1, 4, 4, 0);
        pulses.delete();

        // Clear drops the coincident sample and the partial frame.
        burst(2, 5, 5);
        cyc(9, 9, 1'b1, 1'b1);
        burst(4, 1, 1);
        idle(2);
        chk("t4_count", pulses.size(), 1);
        expect_pulse("t4", 0, 4, 4, 0);
        pulses.delete();

        // Reset mid-frame.
        burst(3, 7, 7);
        @(negedge clk);
        data_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_re", Re_acc, 0);
        chk("t5_rst_im", Im_acc, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        burst(4, -3, 4);
        idle(2);
        chk("t5_count", pulses.size(), 1);
        expect_pulse("t5", 0, -12, 16, 0);
        pulses.delete();

        // Ramp 1..8 back-to-back: two frames, four cycles apart.
        for (int i = 1; i <= 8; i++) burst(1, i, 0);
        idle(2);
        chk("t6_count", pulses.size(), 2);
        expect_pulse("t6a", 0, 10, 0, 0);
        expect_pulse("t6b", 1, 26, 0, 0);
        if (pulses.size() == 2) chk("t6_spacing", pulses[1].cyc - pulses[0].cyc, 4);
        pulses.delete();

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
